alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU: ADD/SUB in one execute cycle, signed MUL via radix-2 Booth over W steps.
// All arithmetic is routed through a single shared 9-bit sign-correct adder.

module alu_sequencer_add8 (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic       flag,
  output logic [8:0] z
);
  logic [8:0] xe, ye;
  assign xe = {x[7], x};
  assign ye = {y[7], y};
  assign z  = flag ? (xe - ye) : (xe + ye);
endmodule

module alu_sequencer #(
  parameter int unsigned W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             busy,
  output logic             done,
  output logic [2*W-1:0]   result,
  output logic             ovf,
  output logic             err
);

  typedef enum logic [1:0] {StIdle, StExec, StMstep, StDone} state_e;

  state_e           state_q;
  logic [1:0]       op_q;
  logic [W-1:0]     a_q, b_q;
  logic [W-1:0]     acc_q, q_q;
  logic             qm1_q;
  logic [3:0]       cnt_q;
  logic [2*W-1:0]   result_q;
  logic             ovf_q, err_q, busy_q, done_q;

  logic [W-1:0]     add_x, add_y;
  logic             add_flag;
  logic [W:0]       add_z;
  logic [W:0]       booth_z;
  logic [2*W-1:0]   mul_res;

  alu_sequencer_add8 u_add (
    .x    (add_x),
    .y    (add_y),
    .flag (add_flag),
    .z    (add_z)
  );

  always_comb begin
    add_x    = a_q;
    add_y    = b_q;
    add_flag = op_q[0];
    if (state_q == StMstep) begin
      add_x    = acc_q;
      add_y    = a_q;
      add_flag = q_q[0];  // {q0,qm1}=10 subtracts, 01 adds
    end
    booth_z = (q_q[0] == qm1_q) ? {acc_q[W-1], acc_q} : add_z;
    mul_res = {booth_z[W:1], booth_z[0], q_q[W-1:1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start) begin
            op_q   <= op;
            a_q    <= a;
            b_q    <= b;
            busy_q <= 1'b1;
            if (op == 2'b10) begin
              acc_q   <= '0;
              q_q     <= b;
              qm1_q   <= 1'b0;
              cnt_q   <= '0;
              state_q <= StMstep;
            end else begin
              state_q <= StExec;
            end
          end
        end
        StExec: begin
          if (op_q == 2'b11) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b1;
          end else begin
            result_q <= {{(W-1){add_z[W]}}, add_z};
            ovf_q    <= add_z[W] ^ add_z[W-1];
            err_q    <= 1'b0;
          end
          done_q  <= 1'b1;
          state_q <= StDone;
        end
        StMstep: begin
          acc_q <= booth_z[W:1];
          q_q   <= {booth_z[0], q_q[W-1:1]};
          qm1_q <= q_q[0];
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == 4'(W-1)) begin
            result_q <= mul_res;
            // Fits in W signed bits only when the top W+1 bits are all equal
            ovf_q    <= !((&mul_res[2*W-1:W-1]) || !(|mul_res[2*W-1:W-1]));
            err_q    <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign ovf    = ovf_q;
  assign err    = err_q;

endmodule
